// File: rtl/spw_cpu_pkg.sv
// Shared definitions for the SpaceWire status CPU port: register map, edge modes, warm-up states.
package spw_cpu_pkg;

    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DATA_W = 32;

    localparam logic [ADDR_W-1:0] REG_DATA = 2'd0;
    localparam logic [ADDR_W-1:0] REG_DIR  = 2'd1;
    localparam logic [ADDR_W-1:0] REG_MASK = 2'd2;
    localparam logic [ADDR_W-1:0] REG_EDGE = 2'd3;

    localparam int unsigned EDGE_RISING  = 0;
    localparam int unsigned EDGE_FALLING = 1;
    localparam int unsigned EDGE_ANY     = 2;

    typedef enum logic [1:0] {
        ST_WARMUP = 2'd0,
        ST_RUN    = 2'd1
    } warm_state_e;

endpackage

// File: rtl/cpu_spw_status_if.sv
// Avalon-MM slave bus bundle for the status input port.
interface cpu_spw_status_if;

    logic [spw_cpu_pkg::ADDR_W-1:0] address;
    logic                           chipselect;
    logic                           write_n;
    logic [spw_cpu_pkg::DATA_W-1:0] writedata;
    logic [spw_cpu_pkg::DATA_W-1:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/spw_bit_sync.sv
// Multi-stage synchroniser bringing asynchronous status lines into the clk domain.
module spw_bit_sync #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [STAGES];

    // Shift chain: stage 0 samples the raw input, last stage is the synchronised value.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= din;
            for (int i = 1; i < int'(STAGES); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout = stage_q[STAGES-1];

endmodule

// File: rtl/cpu_spw_status.sv
// CPU input port for SpaceWire link status: synchronise, capture edges, raise maskable level IRQ.
module cpu_spw_status
    import spw_cpu_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE_TYPE   = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    cpu_spw_status_if.slave        bus,
    input  logic [WIDTH-1:0]       in_port,
    output logic                   irq
);

    localparam int unsigned CNT_W = 3;

    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] p_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] edge_q;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] edge_clr;
    logic             wr_en;
    warm_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             unused_wdata;

    assign unused_wdata = ^bus.writedata;

    spw_bit_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (in_port),
        .dout  (d)
    );

    // Per-bit edge detection against the previous synchronised sample.
    always_comb begin
        edge_det = '0;
        case (EDGE_TYPE)
            EDGE_RISING:  edge_det = d & ~p_q;
            EDGE_FALLING: edge_det = ~d & p_q;
            default:      edge_det = d ^ p_q;
        endcase
    end

    // Bus write decode; edges are only captured once the synchroniser has flushed.
    always_comb begin
        wr_en    = bus.chipselect & ~bus.write_n;
        edge_clr = '0;
        if (wr_en && (bus.address == REG_EDGE)) begin
            edge_clr = bus.writedata[WIDTH-1:0];
        end
        edge_set = (state_q == ST_RUN) ? edge_det : '0;
    end

    // Warm-up FSM: hold off edge capture for SYNC_STAGES+1 clocks after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_WARMUP;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_WARMUP: begin
                    if (cnt_q == CNT_W'(SYNC_STAGES)) begin
                        state_q <= ST_RUN;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_RUN:  state_q <= ST_RUN;
                default: state_q <= ST_WARMUP;
            endcase
        end
    end

    // Previous-sample, mask and edge-capture registers; a new edge beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            p_q    <= '0;
            mask_q <= '0;
            edge_q <= '0;
        end else begin
            p_q    <= d;
            edge_q <= (edge_q & ~edge_clr) | edge_set;
            if (wr_en && (bus.address == REG_MASK)) begin
                mask_q <= bus.writedata[WIDTH-1:0];
            end
        end
    end

    // Registered read mux, updated every clock independent of chipselect.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.readdata <= '0;
        end else begin
            case (bus.address)
                REG_DATA: bus.readdata <= DATA_W'(d);
                REG_DIR:  bus.readdata <= '0;
                REG_MASK: bus.readdata <= DATA_W'(mask_q);
                REG_EDGE: bus.readdata <= DATA_W'(edge_q);
                default:  bus.readdata <= '0;
            endcase
        end
    end

    // Level interrupt from any enabled pending edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq <= 1'b0;
        end else begin
            irq <= |(edge_q & mask_q);
        end
    end

endmodule

// File: tb/tb_cpu_spw_status.sv
// Directed bench for cpu_spw_status: rising-edge instance and any-edge instance side by side.
module tb_cpu_spw_status;
    import spw_cpu_pkg::*;

    logic        clk;
    logic        reset;
    logic [7:0]  in0;
    logic [7:0]  in2;
    logic        irq0;
    logic        irq2;
    int          n_pass;
    int          n_total;
    logic [31:0] rdat;

    cpu_spw_status_if bus0();
    cpu_spw_status_if bus2();

    cpu_spw_status #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0)) dut0 (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus0),
        .in_port (in0),
        .irq     (irq0)
    );

    cpu_spw_status #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(2)) dut2 (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus2),
        .in_port (in2),
        .irq     (irq2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr0(input logic [1:0] a, input logic [31:0] v);
        bus0.address = a; bus0.writedata = v; bus0.chipselect = 1'b1; bus0.write_n = 1'b0;
        tick();
        bus0.chipselect = 1'b0; bus0.write_n = 1'b1;
    endtask

    task automatic wr2(input logic [1:0] a, input logic [31:0] v);
        bus2.address = a; bus2.writedata = v; bus2.chipselect = 1'b1; bus2.write_n = 1'b0;
        tick();
        bus2.chipselect = 1'b0; bus2.write_n = 1'b1;
    endtask

    task automatic rd0(input logic [1:0] a, output logic [31:0] v);
        bus0.address = a; bus0.chipselect = 1'b1;
        tick();
        v = bus0.readdata;
        bus0.chipselect = 1'b0;
    endtask

    task automatic rd2(input logic [1:0] a, output logic [31:0] v);
        bus2.address = a; bus2.chipselect = 1'b1;
        tick();
        v = bus2.readdata;
        bus2.chipselect = 1'b0;
    endtask

    task automatic test_reset();
        in0 = 8'hFF; in2 = 8'h00;
        reset = 1'b1;
        ticks(2);
        n_total++;
        if (bus0.readdata !== 32'h0) $display("FAIL reset_readdata got %h want 0", bus0.readdata); else n_pass++;
        n_total++;
        if (irq0 !== 1'b0) $display("FAIL reset_irq got %b want 0", irq0); else n_pass++;
        reset = 1'b0;
        ticks(3);
        rd0(REG_DATA, rdat);
        n_total++;
        if (rdat !== 32'hFF) $display("FAIL reset_data got %h want 000000ff", rdat); else n_pass++;
        rd0(REG_EDGE, rdat);
        n_total++;
        if (rdat !== 32'h0) $display("FAIL reset_edge got %h want 0", rdat); else n_pass++;
        n_total++;
        if (irq0 !== 1'b0) $display("FAIL reset_irq_after got %b want 0", irq0); else n_pass++;
        rd2(REG_DATA, rdat);
        n_total++;
        if (rdat !== 32'h0) $display("FAIL reset_data2 got %h want 0", rdat); else n_pass++;
    endtask

    task automatic test_rising();
        in0 = 8'h00;
        ticks(4);
        wr0(REG_EDGE, 32'hFF);
        wr0(REG_MASK, 32'h04);
        in0 = 8'h04;
        ticks(3);
        n_total++;
        if (irq0 !== 1'b0) $display("FAIL rise_irq_early got %b want 0", irq0); else n_pass++;
        tick();
        n_total++;
        if (irq0 !== 1'b1) $display("FAIL rise_irq got %b want 1", irq0); else n_pass++;
        rd0(REG_EDGE, rdat);
        n_total++;
        if (rdat !== 32'h04) $display("FAIL rise_edge got %h want 00000004", rdat); else n_pass++;
        rd0(REG_DATA, rdat);
        n_total++;
        if (rdat !== 32'h04) $display("FAIL rise_data got %h want 00000004", rdat); else n_pass++;
        wr0(REG_EDGE, 32'h04);
        n_total++;
        if (irq0 !== 1'b1) $display("FAIL rise_irq_clr_edge got %b want 1", irq0); else n_pass++;
        tick();
        n_total++;
        if (irq0 !== 1'b0) $display("FAIL rise_irq_cleared got %b want 0", irq0); else n_pass++;
        rd0(REG_EDGE, rdat);
        n_total++;
        if (rdat !== 32'h0) $display("FAIL rise_edge_cleared got %h want 0", rdat); else n_pass++;
    endtask

    task automatic test_masking();
        wr0(REG_MASK, 32'h00);
        in0 = 8'h14;
        ticks(4);
        rd0(REG_EDGE, rdat);
        n_total++;
        if (rdat !== 32'h10) $display("FAIL mask_edge got %h want 00000010", rdat); else n_pass++;
        n_total++;
        if (irq0 !== 1'b0) $display("FAIL mask_irq_masked got %b want 0", irq0); else n_pass++;
        wr0(REG_MASK, 32'h10);
        n_total++;
        if (irq0 !== 1'b0) $display("FAIL mask_irq_same_clk got %b want 0", irq0); else n_pass++;
        tick();
        n_total++;
        if (irq0 !== 1'b1) $display("FAIL mask_irq_enabled got %b want 1", irq0); else n_pass++;
        rd0(REG_MASK, rdat);
        n_total++;
        if (rdat !== 32'h10) $display("FAIL mask_read got %h want 00000010", rdat); else n_pass++;
        wr0(REG_EDGE, 32'h10);
        ticks(2);
        n_total++;
        if (irq0 !== 1'b0) $display("FAIL mask_irq_drop got %b want 0", irq0); else n_pass++;
    endtask

    task automatic test_collision();
        in0 = 8'h15;
        ticks(2);
        wr0(REG_EDGE, 32'h01);
        rd0(REG_EDGE, rdat);
        n_total++;
        if (rdat !== 32'h01) $display("FAIL collide_set_wins got %h want 00000001", rdat); else n_pass++;
        wr0(REG_EDGE, 32'h01);
        rd0(REG_EDGE, rdat);
        n_total++;
        if (rdat !== 32'h0) $display("FAIL collide_later_clear got %h want 0", rdat); else n_pass++;
    endtask

    task automatic test_rising_only();
        in0 = 8'h05;
        ticks(4);
        rd0(REG_EDGE, rdat);
        n_total++;
        if (rdat !== 32'h0) $display("FAIL rise_only_fall_ignored got %h want 0", rdat); else n_pass++;
        rd0(REG_DATA, rdat);
        n_total++;
        if (rdat !== 32'h05) $display("FAIL rise_only_data got %h want 00000005", rdat); else n_pass++;
    endtask

    task automatic test_any_edge();
        in2 = 8'h80;
        ticks(5);
        rd2(REG_EDGE, rdat);
        n_total++;
        if (rdat !== 32'h80) $display("FAIL any_first_toggle got %h want 00000080", rdat); else n_pass++;
        wr2(REG_EDGE, 32'h80);
        rd2(REG_EDGE, rdat);
        n_total++;
        if (rdat !== 32'h0) $display("FAIL any_cleared got %h want 0", rdat); else n_pass++;
        in2 = 8'h00;
        ticks(5);
        rd2(REG_EDGE, rdat);
        n_total++;
        if (rdat !== 32'h80) $display("FAIL any_second_toggle got %h want 00000080", rdat); else n_pass++;
        rd2(REG_DIR, rdat);
        n_total++;
        if (rdat !== 32'h0) $display("FAIL any_dir got %h want 0", rdat); else n_pass++;
        wr2(REG_DATA, 32'h55);
        wr2(REG_DIR, 32'hAA);
        rd2(REG_DATA, rdat);
        n_total++;
        if (rdat !== 32'h0) $display("FAIL any_data_ro got %h want 0", rdat); else n_pass++;
        rd2(REG_DIR, rdat);
        n_total++;
        if (rdat !== 32'h0) $display("FAIL any_dir_ro got %h want 0", rdat); else n_pass++;
        rd2(REG_MASK, rdat);
        n_total++;
        if (rdat !== 32'h0) $display("FAIL any_mask_untouched got %h want 0", rdat); else n_pass++;
    endtask

    task automatic test_midrun_reset();
        wr0(REG_MASK, 32'hFF);
        in0 = 8'h00;
        ticks(4);
        wr0(REG_EDGE, 32'hFF);
        in0 = 8'hFF;
        ticks(4);
        n_total++;
        if (irq0 !== 1'b1) $display("FAIL midrst_irq_before got %b want 1", irq0); else n_pass++;
        rd0(REG_EDGE, rdat);
        n_total++;
        if (rdat !== 32'hFF) $display("FAIL midrst_edge_before got %h want 000000ff", rdat); else n_pass++;
        bus0.address = REG_MASK; bus0.writedata = 32'h0F; bus0.chipselect = 1'b1; bus0.write_n = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus0.chipselect = 1'b0; bus0.write_n = 1'b1;
        n_total++;
        if (bus0.readdata !== 32'h0) $display("FAIL midrst_readdata got %h want 0", bus0.readdata); else n_pass++;
        n_total++;
        if (irq0 !== 1'b0) $display("FAIL midrst_irq got %b want 0", irq0); else n_pass++;
        rd0(REG_MASK, rdat);
        n_total++;
        if (rdat !== 32'h0) $display("FAIL midrst_mask got %h want 0", rdat); else n_pass++;
        rd0(REG_EDGE, rdat);
        n_total++;
        if (rdat !== 32'h0) $display("FAIL midrst_edge got %h want 0", rdat); else n_pass++;
        ticks(4);
        rd0(REG_EDGE, rdat);
        n_total++;
        if (rdat !== 32'h0) $display("FAIL midrst_no_warmup_edge got %h want 0", rdat); else n_pass++;
        n_total++;
        if (irq0 !== 1'b0) $display("FAIL midrst_irq_after got %b want 0", irq0); else n_pass++;
        rd0(REG_DATA, rdat);
        n_total++;
        if (rdat !== 32'hFF) $display("FAIL midrst_data got %h want 000000ff", rdat); else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset   = 1'b1;
        in0     = 8'h00;
        in2     = 8'h00;
        bus0.address = 2'd0; bus0.chipselect = 1'b0; bus0.write_n = 1'b1; bus0.writedata = 32'h0;
        bus2.address = 2'd0; bus2.chipselect = 1'b0; bus2.write_n = 1'b1; bus2.writedata = 32'h0;
        test_reset();
        test_rising();
        test_masking();
        test_collision();
        test_rising_only();
        test_any_edge();
        test_midrun_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
